// File: rtl/hm_pkg.sv
// hm_pkg: shared state type, padding constants and byte-swap helper for the hashing datapath
package hm_pkg;
   typedef enum logic [2:0] {IDLE, LOADED, START, WAIT, NEXT, FOUND, EXHAUSTED} feeder_state_t;
   localparam int HDR_WORDS = 20;
   localparam logic [31:0] PAD_WORD = 32'h80000000;
   localparam logic [31:0] LEN_WORD = 32'h00000280;
   function automatic logic [31:0] bswap(input logic [31:0] w);
      return {w[7:0], w[15:8], w[23:16], w[31:24]};
   endfunction
endpackage

// File: rtl/header_feeder_if.sv
// header_feeder_if: chunk/handshake bus between the header feeder and the hashing module
interface header_feeder_if;
   logic [511:0] data_to_hash;
   logic [1:0]   hash_select;
   logic         begin_hash;
   logic         quit_hash;
   logic         hash_done;
   logic         valid_hash_flag;
   modport master (
      output data_to_hash, begin_hash, quit_hash,
      input  hash_select, hash_done, valid_hash_flag
   );
   modport slave (
      input  data_to_hash, begin_hash, quit_hash,
      output hash_select, hash_done, valid_hash_flag
   );
endinterface

// File: rtl/nonce_incr.sv
// nonce_incr: adds one to a nonce stored big-endian but counted as a little-endian integer
module nonce_incr
   import hm_pkg::*;
(
   input  logic [31:0] nonce_in,
   output logic [31:0] nonce_out,
   output logic        wrap
);
   logic [31:0] le_sum;
   assign {wrap, le_sum} = {1'b0, bswap(nonce_in)} + 33'd1;
   assign nonce_out = bswap(le_sum);
endmodule

// File: rtl/header_feeder.sv
// header_feeder: holds a 20-word block header, serves padded chunks and steps the nonce
module header_feeder
   import hm_pkg::*;
(
   input  logic            clk,
   input  logic            n_rst,
   input  logic            load_word,
   input  logic [31:0]     word_in,
   input  logic            start_mining,
   input  logic            stop_mining,
   header_feeder_if.master hash,
   output logic            header_loaded,
   output logic            busy,
   output logic            found,
   output logic            exhausted,
   output logic [31:0]     nonce
);
   feeder_state_t    state;
   logic [31:0]      hdr [HDR_WORDS];
   logic [4:0]       cnt;
   logic [31:0]      nonce_next;
   logic             wrap;
   logic [31:0]      msg [32];
   logic [15:0][31:0] chunk;

   nonce_incr u_incr (.nonce_in(hdr[HDR_WORDS-1]), .nonce_out(nonce_next), .wrap(wrap));

   for (genvar i = 0; i < 32; i++) begin : g_msg
      if (i < HDR_WORDS) begin : g_hdr
         assign msg[i] = hdr[i];
      end else if (i == HDR_WORDS) begin : g_pad
         assign msg[i] = PAD_WORD;
      end else if (i == 31) begin : g_len
         assign msg[i] = LEN_WORD;
      end else begin : g_zero
         assign msg[i] = '0;
      end
   end

   for (genvar i = 0; i < 16; i++) begin : g_chunk
      assign chunk[i] = (hash.hash_select == 2'd1) ? msg[16+i] : msg[i];
   end

   assign hash.data_to_hash = chunk;
   assign nonce = hdr[HDR_WORDS-1];

   // header loading and mining control with registered pulses and status levels
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state           <= IDLE;
         hdr             <= '{default: '0};
         cnt             <= '0;
         hash.begin_hash <= 1'b0;
         hash.quit_hash  <= 1'b0;
         header_loaded   <= 1'b0;
         busy            <= 1'b0;
         found           <= 1'b0;
         exhausted       <= 1'b0;
      end else begin
         hash.begin_hash <= 1'b0;
         hash.quit_hash  <= 1'b0;
         case (state)
            IDLE:
               if (load_word) begin
                  hdr[cnt] <= word_in;
                  cnt      <= cnt + 5'd1;
                  if (cnt == 5'(HDR_WORDS - 1)) begin
                     header_loaded <= 1'b1;
                     state         <= LOADED;
                  end
               end
            LOADED, FOUND, EXHAUSTED:
               if (load_word) begin
                  hdr[0]        <= word_in;
                  cnt           <= 5'd1;
                  header_loaded <= 1'b0;
                  found         <= 1'b0;
                  exhausted     <= 1'b0;
                  state         <= IDLE;
               end else if (start_mining) begin
                  hash.begin_hash <= 1'b1;
                  busy            <= 1'b1;
                  found           <= 1'b0;
                  exhausted       <= 1'b0;
                  state           <= START;
               end
            START, WAIT, NEXT:
               if (stop_mining) begin
                  hash.quit_hash <= 1'b1;
                  busy           <= 1'b0;
                  state          <= LOADED;
               end else if (state == START) begin
                  state <= WAIT;
               end else if (state == WAIT) begin
                  if (hash.valid_hash_flag) begin
                     busy  <= 1'b0;
                     found <= 1'b1;
                     state <= FOUND;
                  end else if (hash.hash_done) begin
                     busy      <= !wrap;
                     exhausted <= wrap;
                     state     <= wrap ? EXHAUSTED : NEXT;
                  end
               end else begin
                  hdr[HDR_WORDS-1] <= nonce_next;
                  hash.begin_hash  <= 1'b1;
                  state            <= START;
               end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_header_feeder.sv
// tb_header_feeder: randomized self-checking bench against a message/nonce reference model
module tb_header_feeder;
   logic        tb_clk = 1'b0;
   logic        n_rst;
   logic        load_word;
   logic [31:0] word_in;
   logic        start_mining;
   logic        stop_mining;
   logic        header_loaded, busy, found, exhausted;
   logic [31:0] nonce;
   logic [31:0] hdr_m [20];
   logic [31:0] w;
   int          n_checks = 0;
   int          n_fails = 0;

   header_feeder_if hif ();

   header_feeder dut (
      .clk(tb_clk), .n_rst(n_rst), .load_word(load_word), .word_in(word_in),
      .start_mining(start_mining), .stop_mining(stop_mining), .hash(hif),
      .header_loaded(header_loaded), .busy(busy), .found(found),
      .exhausted(exhausted), .nonce(nonce)
   );

   always #5 tb_clk = ~tb_clk;

   task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] msg_word(input int i);
      if (i < 20) return hdr_m[i];
      if (i == 20) return 32'h80000000;
      if (i == 31) return 32'h00000280;
      return 32'h0;
   endfunction

   function automatic logic [511:0] model_chunk(input logic [1:0] sel);
      logic [511:0] c;
      int base;
      base = (sel == 2'd1) ? 16 : 0;
      for (int i = 0; i < 16; i++) c[32*i +: 32] = msg_word(base + i);
      return c;
   endfunction

   function automatic logic [31:0] next_nonce(input logic [31:0] n);
      logic [31:0] le;
      le = {<<8{n}};
      le = le + 32'd1;
      return {<<8{le}};
   endfunction

   task automatic cycle();
      @(posedge tb_clk);
      #1;
      load_word = 1'b0;
      start_mining = 1'b0;
      stop_mining = 1'b0;
      hif.hash_done = 1'b0;
      hif.valid_hash_flag = 1'b0;
   endtask

   task automatic check_chunks();
      for (int s = 0; s < 4; s++) begin
         hif.hash_select = 2'(s);
         #1;
         check("chunk", hif.data_to_hash, model_chunk(2'(s)));
      end
      hif.hash_select = 2'd0;
   endtask

   task automatic load_header(input logic [31:0] w19);
      hdr_m[0] = 32'h01000000;
      hdr_m[1] = 32'h50120119;
      for (int i = 2; i < 19; i++) hdr_m[i] = $urandom;
      hdr_m[19] = w19;
      for (int i = 0; i < 20; i++) begin
         word_in = hdr_m[i];
         load_word = 1'b1;
         cycle();
         if (i < 19) check("loaded_early", header_loaded, 1'b0);
      end
      check("loaded", header_loaded, 1'b1);
   endtask

   task automatic start_pulse();
      start_mining = 1'b1;
      cycle();
      check("begin_on_start", hif.begin_hash, 1'b1);
      check("busy_start", busy, 1'b1);
      check("found_cleared", found, 1'b0);
      check("exh_cleared", exhausted, 1'b0);
      cycle();
      check("begin_one_cycle", hif.begin_hash, 1'b0);
      repeat ($urandom_range(0, 3)) begin
         cycle();
         check("wait_quiet", hif.begin_hash, 1'b0);
      end
   endtask

   task automatic hash_miss();
      logic [31:0] exp_n;
      exp_n = next_nonce(hdr_m[19]);
      hif.hash_done = 1'b1;
      cycle();
      check("gap_no_begin", hif.begin_hash, 1'b0);
      check("gap_busy", busy, 1'b1);
      check("gap_nonce", nonce, hdr_m[19]);
      cycle();
      hdr_m[19] = exp_n;
      check("rebegin", hif.begin_hash, 1'b1);
      check("nonce_inc", nonce, exp_n);
      cycle();
      check("rebegin_one", hif.begin_hash, 1'b0);
   endtask

   task automatic stop_now();
      stop_mining = 1'b1;
      cycle();
      check("quit", hif.quit_hash, 1'b1);
      check("busy_stop", busy, 1'b0);
      check("found_stop", found, 1'b0);
      check("nonce_stop", nonce, hdr_m[19]);
      check("loaded_stop", header_loaded, 1'b1);
      cycle();
      check("quit_one", hif.quit_hash, 1'b0);
   endtask

   initial begin
      n_rst = 1'b0;
      load_word = 1'b0;
      word_in = '0;
      start_mining = 1'b0;
      stop_mining = 1'b0;
      hif.hash_done = 1'b0;
      hif.valid_hash_flag = 1'b0;
      hif.hash_select = 2'd0;
      for (int i = 0; i < 20; i++) hdr_m[i] = '0;
      cycle();
      cycle();
      check("rst_loaded", header_loaded, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_found", found, 1'b0);
      check("rst_exh", exhausted, 1'b0);
      check("rst_begin", hif.begin_hash, 1'b0);
      check("rst_quit", hif.quit_hash, 1'b0);
      check("rst_nonce", nonce, 32'h0);
      n_rst = 1'b1;
      cycle();
      check_chunks();
      start_mining = 1'b1;
      cycle();
      check("start_idle_ignored", hif.begin_hash, 1'b0);

      load_header(32'h0f2b5710);
      check_chunks();
      hif.hash_select = 2'd1;
      #1;
      check("word3", hif.data_to_hash[127:96], 32'h0f2b5710);
      check("word4", hif.data_to_hash[159:128], 32'h80000000);
      check("word15", hif.data_to_hash[511:480], 32'h00000280);
      hif.hash_select = 2'd0;

      start_pulse();
      hash_miss();
      check("nonce_first_inc", nonce, 32'h102b5710);
      hash_miss();
      check_chunks();

      hif.hash_done = 1'b1;
      hif.valid_hash_flag = 1'b1;
      cycle();
      check("found", found, 1'b1);
      check("found_busy", busy, 1'b0);
      check("found_nonce", nonce, hdr_m[19]);
      repeat (3) begin
         cycle();
         check("found_no_begin", hif.begin_hash, 1'b0);
         check("found_hold", found, 1'b1);
      end

      start_pulse();
      check("restart_nonce", nonce, hdr_m[19]);
      hif.hash_done = 1'b1;
      hif.valid_hash_flag = 1'b1;
      stop_now();
      stop_mining = 1'b1;
      cycle();
      check("stop_loaded_ignored", hif.quit_hash, 1'b0);
      start_mining = 1'b1;
      cycle();
      check("begin_from_loaded", hif.begin_hash, 1'b1);
      stop_now();

      load_header(32'hFFFFFFFF);
      start_pulse();
      hif.hash_done = 1'b1;
      cycle();
      check("exhausted", exhausted, 1'b1);
      check("exh_busy", busy, 1'b0);
      check("exh_nonce", nonce, 32'hFFFFFFFF);
      repeat (2) begin
         cycle();
         check("exh_no_begin", hif.begin_hash, 1'b0);
      end
      start_pulse();
      stop_now();

      for (int r = 0; r < 6; r++) begin
         w = $urandom;
         if (r % 2 == 1) w[31:24] = 8'hFF;
         w[7:0] = 8'($urandom_range(0, 254));
         load_header(w);
         check_chunks();
         start_pulse();
         repeat ($urandom_range(1, 3)) hash_miss();
         check_chunks();
         if ($urandom_range(0, 1) == 1) begin
            hif.valid_hash_flag = 1'b1;
            hif.hash_done = 1'($urandom_range(0, 1));
            cycle();
            check("rnd_found", found, 1'b1);
            check("rnd_found_nonce", nonce, hdr_m[19]);
            start_pulse();
         end
         stop_now();
      end

      start_pulse();
      #2;
      n_rst = 1'b0;
      #1;
      for (int i = 0; i < 20; i++) hdr_m[i] = '0;
      check("arst_busy", busy, 1'b0);
      check("arst_loaded", header_loaded, 1'b0);
      check("arst_nonce", nonce, 32'h0);
      check("arst_begin", hif.begin_hash, 1'b0);
      check("arst_quit", hif.quit_hash, 1'b0);
      check("arst_found", found, 1'b0);
      check("arst_exh", exhausted, 1'b0);
      check("arst_chunk", hif.data_to_hash, model_chunk(2'd0));
      cycle();
      check("arst_no_quit", hif.quit_hash, 1'b0);
      check("arst_busy_hold", busy, 1'b0);
      n_rst = 1'b1;
      cycle();
      check("post_rst_loaded", header_loaded, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end
endmodule
